// File: rtl/nibble_serial_alu_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/nibble_serial_alu_addsub_slice4.sv
// Combinational 4-bit add/subtract slice. It exposes the carry into bit 3
// so the top level can derive signed overflow on the last nibble.
module addsub_slice4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       Ctrl,
  output logic [3:0] S,
  output logic       C3,
  output logic       Co
);

  logic [3:0] b_x;
  logic [3:0] low;
  logic [1:0] high;

  always_comb begin
    b_x  = B ^ {4{Ctrl}};
    low  = {1'b0, A[2:0]} + {1'b0, b_x[2:0]} + {3'b000, Cin};
    high = {1'b0, A[3]} + {1'b0, b_x[3]} + {1'b0, low[3]};
    S    = {high[0], low[2:0]};
    C3   = low[3];
    Co   = high[1];
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial A+B / A-B unit: one 4-bit slice reused over WIDTH/4 cycles,
// with flags and result registered together when the last nibble completes.
module nibble_serial_alu
  import nibble_serial_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  alu_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ctrl_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;

  logic [NIBBLE_W-1:0] sum_n;
  logic                c3;
  logic                co;
  logic [WIDTH-1:0]    res_next;

  addsub_slice4 u_slice (
    .A    (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .B    (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .Cin  (carry_q),
    .Ctrl (ctrl_q),
    .S    (sum_n),
    .C3   (c3),
    .Co   (co)
  );

  // Accumulator with the current nibble merged in; on the last RUN cycle
  // this is the complete result.
  always_comb begin
    res_next = acc;
    res_next[idx*NIBBLE_W +: NIBBLE_W] = sum_n;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            ctrl_q  <= Ctrl;
            carry_q <= Ctrl;
            idx     <= '0;
            acc     <= '0;
            Busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          carry_q <= co;
          acc     <= res_next;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            S     <= res_next;
            Cout  <= co ^ ctrl_q;
            V     <= c3 ^ co;
            Z     <= (res_next == '0);
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_alu.md
NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 and at least 8.
REQ-002 Clock  in  1  rising-edge system clock.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 Ctrl  in  1  operation select: 0 = A+B, 1 = A-B.
REQ-006 A  in  WIDTH  first operand, sampled on the accepted Start.
REQ-007 B  in  WIDTH  second operand, sampled on the accepted Start.
REQ-008 Busy  out  1  high whenever the state is not IDLE.
REQ-009 Done  out  1  single-cycle pulse marking valid results.
REQ-010 S  out  WIDTH  result of A+B or A-B, modulo 2^WIDTH.
REQ-011 Cout  out  1  for add: carry out; for sub: borrow (internal carry XOR Ctrl).
REQ-012 V  out  1  signed two's-complement overflow.
REQ-013 Z  out  1  high when S equals zero.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE, Start=1 SHALL latch A, B and Ctrl, load the carry register with Ctrl, clear the nibble index, and move to RUN on the same edge.
REQ-016 In IDLE, Start=0 SHALL leave the FSM in IDLE.
REQ-017 Each RUN cycle SHALL process one 4-bit nibble, LSB nibble first: A nibble + (B nibble XOR {4{Ctrl}}) + carry register.
REQ-018 At the end of each RUN cycle, the carry register SHALL update with the nibble carry-out, the sum nibble SHALL go into an internal accumulator, and the index SHALL increment.
REQ-019 RUN SHALL last exactly N = WIDTH/4 cycles; on the edge that processes nibble N-1 the FSM SHALL move to DONE.
REQ-020 On the RUN-to-DONE edge, S, Cout, V and Z SHALL load together.
REQ-021 Cout SHALL equal the final carry XOR Ctrl.
REQ-022 V SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 Z SHALL be computed from the final WIDTH-bit result.
REQ-024 DONE SHALL last one cycle with Done=1, then return to IDLE unconditionally.
REQ-025 Latency: a Start accepted at edge t SHALL give Done=1 in the cycle after edge t+N; for WIDTH=16 that is 5 cycles after Start.
REQ-026 S, Cout, V and Z SHALL hold their values from DONE until the next RUN-to-DONE edge; they SHALL NOT change during RUN.
REQ-027 Start, A, B and Ctrl SHALL be ignored in RUN and DONE; back-to-back operations need Start in the IDLE cycle after Done.
REQ-028 Input changes after acceptance SHALL NOT affect the result in progress.
REQ-029 Busy SHALL be 0 in IDLE and 1 in RUN and DONE.
REQ-030 Done SHALL be 0 in every state except DONE.

Reset
REQ-031 Reset asserted SHALL immediately force IDLE, with Busy=0, Done=0, S=0, Cout=0, V=0, Z=0, and all internal operand, carry, index and accumulator registers at 0.
REQ-032 Reset during RUN or DONE SHALL abort the operation; no Done pulse SHALL follow.
REQ-033 The first Start SHALL be accepted on the first rising edge after Reset deasserts.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIBBLE_W = 4.
REQ-035 The per-cycle nibble arithmetic SHALL live in one sub-module, addsub_slice4.
REQ-036 addsub_slice4 SHALL be combinational with ports: A[3:0], B[3:0], Cin, Ctrl, S[3:0], C3 (carry into bit 3), Co (carry out of bit 3).
REQ-037 The top level SHALL contain only the FSM, the registers and a single addsub_slice4 instance.

Verification
REQ-038 Add 0x1234 + 0x4321 -> S=0x5555, Cout=0, V=0, Z=0, Done exactly 5 cycles after Start.
REQ-039 Add 0xFFFF + 0x0001 -> S=0x0000, Cout=1, V=0, Z=1; and add 0x7FFF + 0x0001 -> S=0x8000, V=1, Cout=0.
REQ-040 Sub 0x0005 - 0x0007 -> S=0xFFFE, Cout=1 (borrow), V=0, Z=0.
REQ-041 Sub 0x8000 - 0x0001 -> S=0x7FFF, Cout=0, V=1.
REQ-042 Start held high with new A/B throughout RUN -> first result unchanged, one Done pulse only; the next op starts only from IDLE.
REQ-043 Reset pulse in the 2nd RUN cycle -> Busy=0 and all outputs 0 at once, no Done; a following Start completes normally.
